uart_tx: RTL



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tx_if.sv | 26 ++
 rtl/baud_tick_detect.sv | 30 +++
 rtl/uart_tx.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmitter FSM state encoding, the PARITY parameter codes and
// the clock/baud constants that uart_tx shares with the baudrate generator.
// No ports; imported with `import uart_pkg::*;`.
package uart_pkg;

    // FSM state encoding, kept as plain constants so the encoding matches the
    // legacy netlists bit for bit.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_TICK = 3'd1;
    localparam state_t ST_START     = 3'd2;
    localparam state_t ST_DATA      = 3'd3;
    localparam state_t ST_PARITY    = 3'd4;
    localparam state_t ST_STOP      = 3'd5;

    // Values for the PARITY parameter.
    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // System clock and the supported line rates.
    localparam int unsigned SOURCE_CLK  = 50_000_000;
    localparam int unsigned BAUD_9600   = 9600;
    localparam int unsigned BAUD_57600  = 57600;
    localparam int unsigned BAUD_115200 = 115200;

    // Clock cycles per bit for a given line rate.
    function automatic int unsigned baud_divisor(input int unsigned baud);
        return SOURCE_CLK / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side word handshake of the UART transmitter.
//   tx_data  : word to send, sampled on the handshake edge
//   tx_valid : source has a word
//   tx_ready : transmitter can accept a word
// master = byte source, slave = uart_tx.
interface uart_tx_if #(
    parameter int unsigned DATA_BITS = 8
);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/baud_tick_detect.sv
// Converts the baud timing input into a one-cycle tick.
//   clock    : system clock
//   reset_n  : asynchronous active-low reset
//   baud_in  : square wave (TICK_EDGE=1) or one-cycle strobe (TICK_EDGE=0)
//   tick     : one-cycle pulse per bit interval
// Written to be shared with a future uart_rx.
module baud_tick_detect #(
    parameter int unsigned TICK_EDGE = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic baud_in,
    output logic tick
);

    // History resets to 1 so a line that is already high when reset is
    // released is not mistaken for a rising edge.
    logic baud_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            baud_prev <= 1'b1;
        end else begin
            baud_prev <= baud_in;
        end
    end

    assign tick = (TICK_EDGE != 0) ? (baud_in & ~baud_prev) : baud_in;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter.
// Accepts one word per valid/ready handshake and sends it on tx as start bit,
// DATA_BITS data bits LSB first, optional parity bit and STOP_BITS stop bits.
// All bit timing comes from baud_in; there is no internal divider.
//   clock    : system clock
//   reset_n  : asynchronous active-low reset
//   baud_in  : baud timing from the baudrate generator
//   host     : word handshake (tx_data / tx_valid / tx_ready)
//   tx       : serial line, idle high
//   tx_busy  : frame in progress, from acceptance until the frame ends
//   tx_done  : one-cycle pulse when the final stop bit completes
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned TICK_EDGE = 1
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      baud_in,
    uart_tx_if.slave  host,
    output logic      tx,
    output logic      tx_busy,
    output logic      tx_done
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_cnt;
    logic                 parity_acc;
    logic                 parity_bit;
    logic                 tick;
    logic                 accept;

    baud_tick_detect #(
        .TICK_EDGE (TICK_EDGE)
    ) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .baud_in (baud_in),
        .tick    (tick)
    );

    // Ready is decoded from the state, so it rises in the same cycle as the
    // tx_done pulse and a held tx_valid is taken on the very next edge.
    assign host.tx_ready = (state == ST_IDLE);
    assign tx_busy       = ~host.tx_ready;
    assign accept        = host.tx_valid & host.tx_ready;

    // parity_acc holds the XOR of all data bits once the last one is driven.
    assign parity_bit = (PARITY == PARITY_EVEN) ? parity_acc : ~parity_acc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            parity_acc <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        shreg <= host.tx_data;
                        state <= ST_WAIT_TICK;
                    end
                end

                // A tick in the acceptance cycle is seen while still in IDLE,
                // so the start bit always waits for the next full interval.
                ST_WAIT_TICK: begin
                    if (tick) begin
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        tx         <= shreg[0];
                        parity_acc <= shreg[0];
                        shreg      <= shreg >> 1;
                        bit_cnt    <= '0;
                        state      <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY != PARITY_NONE) begin
                                tx    <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            tx         <= shreg[0];
                            parity_acc <= parity_acc ^ shreg[0];
                            shreg      <= shreg >> 1;
                            bit_cnt    <= bit_cnt + 4'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end
                end

                // bit_cnt is reused to count stop intervals.
                ST_STOP: begin
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            tx_done <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
